pipe_field: RTL and testbench

PIPE_FIELD -- requirements
Module: pipe_field

---
 rtl/flappy_pkg.sv | 36 +++
 rtl/lfsr8.sv | 28 ++
 rtl/pipe_field.sv | 145 ++++++++++++++
 tb/tb_pipe_field.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared Flappy constants, FSM encoding, pipe record and the LFSR step function.
// Pipe and LFSR widths are sized for the 640x480 playfield.
package flappy_pkg;

  localparam int BIRD_X    = 160;
  localparam int BIRD_H    = 16;
  localparam int PIPE_W    = 40;
  localparam int GAP_H     = 120;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int GAP_MIN   = 80;
  localparam int GAP_RESET = 200;
  localparam int NUM_PIPES = 3;

  localparam logic [7:0] LFSR_SEED = 8'hB5;
  // Galois toggle mask for x^8+x^6+x^5+x^4+1 in right-shift form
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  typedef struct packed {
    logic [10:0] x;
    logic [8:0]  gap_lo;
  } pipe_t;

  typedef pipe_t [NUM_PIPES-1:0] pipes_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length Galois LFSR, one step per clock.
// Seeded on synchronous reset; never reaches the all-zero state.
module lfsr8
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/pipe_field.sv
// Three scrolling pipes, collision detection, score and the IDLE/RUN/DEAD game FSM.
// All outputs are registered; a flap rise or tick takes effect on the next clock edge.
module pipe_field
  import flappy_pkg::*;
#(
  parameter int SPEED   = 2,
  parameter int SPACING = 220
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              flap,
  input  logic signed [9:0] bird_y,
  output logic [10:0]       pipe0_x,
  output logic [10:0]       pipe1_x,
  output logic [10:0]       pipe2_x,
  output logic [8:0]        pipe0_gap,
  output logic [8:0]        pipe1_gap,
  output logic [8:0]        pipe2_gap,
  output logic [7:0]        score,
  output logic [1:0]        state
);

  localparam logic [10:0] RESPAWN_X = 11'(3 * SPACING - SPEED);
  localparam logic [10:0] STEP_X    = 11'(SPEED);
  // A pipe whose left edge sits here has its right edge just crossing the bird
  localparam logic [10:0] SCORE_X   = 11'(BIRD_X - PIPE_W);
  localparam logic [8:0]  GAP_BASE  = 9'(GAP_MIN);

  localparam logic signed [12:0] BIRD_L = 13'(BIRD_X);
  localparam logic signed [12:0] BIRD_R = 13'(BIRD_X + BIRD_H - 1);
  localparam logic signed [12:0] PIPE_R = 13'(PIPE_W - 1);
  localparam logic signed [12:0] BIRD_T = 13'(BIRD_H - 1);
  localparam logic signed [12:0] GAP_T  = 13'(GAP_H);

  state_e      state_q, state_d;
  pipes_t      pipes_q, pipes_d;
  logic [7:0]  score_q, score_d;
  logic        flap_q;
  logic        flap_rise;
  logic        hit;
  logic [7:0]  lfsr;

  function automatic pipes_t init_pipes();
    pipes_t p;
    for (int i = 0; i < NUM_PIPES; i++) begin
      p[i].x      = 11'(SCREEN_W + i * SPACING);
      p[i].gap_lo = 9'(GAP_RESET);
    end
    return p;
  endfunction

  // Bird box overlaps the pipe columns and is not wholly inside the gap
  function automatic logic pipe_hit(input pipe_t p, input logic signed [9:0] by);
    logic signed [12:0] px;
    logic signed [12:0] y;
    logic signed [12:0] g;
    px = signed'({2'b00, p.x});
    y  = {{3{by[9]}}, by};
    g  = signed'({4'b0000, p.gap_lo});
    return (px <= BIRD_R) && (px + PIPE_R >= BIRD_L) &&
           ((y < g) || (y + BIRD_T > g + GAP_T));
  endfunction

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign flap_rise = flap & ~flap_q;

  always_comb begin
    hit = (bird_y <= 10'sd0);
    for (int i = 0; i < NUM_PIPES; i++) begin
      hit = hit | pipe_hit(pipes_q[i], bird_y);
    end
  end

  always_comb begin
    state_d = state_q;
    pipes_d = pipes_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE: begin
        if (flap_rise) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (hit) begin
            state_d = ST_DEAD;
          end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              if (pipes_q[i].x == SCORE_X && score_d != 8'hFF) begin
                score_d = score_d + 8'd1;
              end
              if (pipes_q[i].x == 11'd0) begin
                pipes_d[i].x      = RESPAWN_X;
                pipes_d[i].gap_lo = GAP_BASE + {1'b0, lfsr};
              end else begin
                pipes_d[i].x = pipes_q[i].x - STEP_X;
              end
            end
          end
        end
      end
      ST_DEAD: begin
        if (flap_rise) begin
          state_d = ST_IDLE;
          pipes_d = init_pipes();
          score_d = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pipes_q <= init_pipes();
      score_q <= 8'd0;
      flap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pipes_q <= pipes_d;
      score_q <= score_d;
      flap_q  <= flap;
    end
  end

  assign pipe0_x   = pipes_q[0].x;
  assign pipe1_x   = pipes_q[1].x;
  assign pipe2_x   = pipes_q[2].x;
  assign pipe0_gap = pipes_q[0].gap_lo;
  assign pipe1_gap = pipes_q[1].gap_lo;
  assign pipe2_gap = pipes_q[2].gap_lo;
  assign score     = score_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_field.sv
// Directed stimulus for pipe_field; expectations queue up at drive time and a
// monitor pops and compares them just after each rising edge.
module tb_pipe_field;
  import flappy_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              flap;
  logic signed [9:0] bird_y;
  logic [10:0]       pipe0_x, pipe1_x, pipe2_x;
  logic [8:0]        pipe0_gap, pipe1_gap, pipe2_gap;
  logic [7:0]        score;
  logic [1:0]        state;

  pipe_field #(.SPEED(2), .SPACING(220)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .flap      (flap),
    .bird_y    (bird_y),
    .pipe0_x   (pipe0_x),
    .pipe1_x   (pipe1_x),
    .pipe2_x   (pipe2_x),
    .pipe0_gap (pipe0_gap),
    .pipe1_gap (pipe1_gap),
    .pipe2_gap (pipe2_gap),
    .score     (score),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [10:0] x0, x1, x2;
    logic [8:0]  g0, g1, g2;
    logic [7:0]  sc;
    logic        rng;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  logic [1:0]  e_st;
  logic [10:0] e_x0, e_x1, e_x2;
  logic [8:0]  e_g0, e_g1, e_g2;
  logic [7:0]  e_sc;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 0xB5, stepping every clock
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hB5;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  exp_t  mon_e;
  string mon_nm;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_total++;
      if ({state, pipe0_x, pipe1_x, pipe2_x, pipe0_gap, pipe1_gap, pipe2_gap, score} ===
          {mon_e.st, mon_e.x0, mon_e.x1, mon_e.x2, mon_e.g0, mon_e.g1, mon_e.g2, mon_e.sc}) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got st=%0d x=%0d/%0d/%0d gap=%0d/%0d/%0d score=%0d, want st=%0d x=%0d/%0d/%0d gap=%0d/%0d/%0d score=%0d",
                 mon_nm, state, pipe0_x, pipe1_x, pipe2_x, pipe0_gap, pipe1_gap, pipe2_gap, score,
                 mon_e.st, mon_e.x0, mon_e.x1, mon_e.x2, mon_e.g0, mon_e.g1, mon_e.g2, mon_e.sc);
      end
      if (mon_e.rng) begin
        n_total++;
        if (pipe0_gap >= 9'(GAP_MIN) && pipe0_gap <= 9'd335 &&
            10'(pipe0_gap) + 10'(GAP_H) < 10'(SCREEN_H)) begin
          n_pass++;
        end else begin
          $display("FAIL %s_range: got gap=%0d, want 80..335", mon_nm, pipe0_gap);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic t, input logic f, input logic signed [9:0] by);
    @(negedge clk);
    rst    = r;
    tick   = t;
    flap   = f;
    bird_y = by;
  endtask

  task automatic push(input string nm, input logic rng);
    exp_t e;
    e.st  = e_st;
    e.x0  = e_x0;
    e.x1  = e_x1;
    e.x2  = e_x2;
    e.g0  = e_g0;
    e.g1  = e_g1;
    e.g2  = e_g2;
    e.sc  = e_sc;
    e.rng = rng;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_reset_vals();
    e_st = 2'b00;
    e_x0 = 11'd640;
    e_x1 = 11'd860;
    e_x2 = 11'd1080;
    e_g0 = 9'd200;
    e_g1 = 9'd200;
    e_g2 = 9'd200;
    e_sc = 8'd0;
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, 1'b0, 10'sd250);
      drive(1'b0, 1'b0, 1'b0, 10'sd250);
    end
  endtask

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    flap   = 1'b0;
    bird_y = 10'sd250;
    set_reset_vals();

    drive(1'b1, 1'b0, 1'b0, 10'sd250);
    drive(1'b1, 1'b1, 1'b1, 10'sd250); push("reset", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("reset_release", 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, 10'sd250); push("idle_tick", 1'b0);
    end

    // flap rise with a simultaneous tick: RUN, but no motion this cycle
    drive(1'b0, 1'b1, 1'b1, 10'sd250); e_st = 2'b01; push("start_run", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 10'sd250); push("flap_held", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);

    do_ticks(10);
    e_x0 = 11'd620; e_x1 = 11'd840; e_x2 = 11'd1060;
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("run10", 1'b0);

    do_ticks(250);
    e_x0 = 11'd120; e_x1 = 11'd340; e_x2 = 11'd560;
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("at120", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd250);
    e_x0 = 11'd118; e_x1 = 11'd338; e_x2 = 11'd558; e_sc = 8'd1;
    push("score_cross", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);

    do_ticks(59);
    e_x0 = 11'd0; e_x1 = 11'd220; e_x2 = 11'd440;
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("at0", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd250);
    e_x0 = 11'd658; e_g0 = 9'd80 + {1'b0, m_lfsr}; e_x1 = 11'd218; e_x2 = 11'd438;
    push("respawn", 1'b1);

    drive(1'b0, 1'b1, 1'b0, 10'sd0); e_st = 2'b10; push("ground_hit", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd250); push("dead_frozen", 1'b0);
    drive(1'b0, 1'b1, 1'b1, 10'sd250); set_reset_vals(); push("dead_to_idle", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("idle_after_dead", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 10'sd250); e_st = 2'b01; push("restart", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);

    do_ticks(233);
    e_x0 = 11'd174; e_x1 = 11'd394; e_x2 = 11'd614;
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("at174", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd100); e_st = 2'b10; push("pipe_hit", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd250); push("hit_frozen", 1'b0);
    drive(1'b0, 1'b0, 1'b1, 10'sd250); set_reset_vals(); push("dead_idle2", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);
    drive(1'b0, 1'b0, 1'b1, 10'sd250); e_st = 2'b01; push("run3", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);

    do_ticks(5);
    e_x0 = 11'd630; e_x1 = 11'd850; e_x2 = 11'd1070;
    drive(1'b0, 1'b0, 1'b0, 10'sd250); push("run3_move", 1'b0);
    drive(1'b1, 1'b1, 1'b0, 10'sd250); set_reset_vals(); push("mid_run_rst", 1'b0);
    drive(1'b0, 1'b1, 1'b0, 10'sd250); push("post_rst_idle", 1'b0);

    drive(1'b0, 1'b0, 1'b0, 10'sd250);
    drive(1'b0, 1'b0, 1'b0, 10'sd250);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
